// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: FSM states, ALU control
// codes, condition codes and the data-processing command decode table.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    HALT   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  localparam logic [3:0] CMD_AND = 4'd0;
  localparam logic [3:0] CMD_EOR = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_RSB = 4'd3;
  localparam logic [3:0] CMD_ADD = 4'd4;
  localparam logic [3:0] CMD_ADC = 4'd5;
  localparam logic [3:0] CMD_SBC = 4'd6;
  localparam logic [3:0] CMD_RSC = 4'd7;
  localparam logic [3:0] CMD_TST = 4'd8;
  localparam logic [3:0] CMD_TEQ = 4'd9;
  localparam logic [3:0] CMD_CMP = 4'd10;
  localparam logic [3:0] CMD_CMN = 4'd11;
  localparam logic [3:0] CMD_ORR = 4'd12;
  localparam logic [3:0] CMD_MOV = 4'd13;
  localparam logic [3:0] CMD_BIC = 4'd14;
  localparam logic [3:0] CMD_MVN = 4'd15;

  typedef struct packed {
    logic       supported;
    logic       writes_rd;
    logic [2:0] alu_ctl;
    logic       swap;
    logic       inv;
    logic       use_carry;
    logic       shift;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d           = '0;
    d.supported = 1'b1;
    d.writes_rd = 1'b1;
    case (cmd)
      CMD_AND: d.alu_ctl = ALU_AND;
      CMD_EOR: d.alu_ctl = ALU_EOR;
      CMD_SUB: d.alu_ctl = ALU_SUB;
      CMD_RSB: begin d.alu_ctl = ALU_SUB; d.swap = 1'b1; end
      CMD_ADD: d.alu_ctl = ALU_ADD;
      CMD_ADC: begin d.alu_ctl = ALU_ADD; d.use_carry = 1'b1; end
      CMD_SBC: begin d.alu_ctl = ALU_SUB; d.use_carry = 1'b1; end
      CMD_TST: begin d.alu_ctl = ALU_AND; d.writes_rd = 1'b0; end
      CMD_TEQ: begin d.alu_ctl = ALU_EOR; d.writes_rd = 1'b0; end
      CMD_CMP: begin d.alu_ctl = ALU_SUB; d.writes_rd = 1'b0; end
      CMD_CMN: begin d.alu_ctl = ALU_ADD; d.writes_rd = 1'b0; end
      CMD_ORR: d.alu_ctl = ALU_ORR;
      CMD_MOV: begin d.alu_ctl = ALU_MOV; d.shift = 1'b1; end
      CMD_BIC: begin d.alu_ctl = ALU_AND; d.inv = 1'b1; end
      CMD_MVN: begin d.alu_ctl = ALU_MOV; d.inv = 1'b1; d.shift = 1'b1; end
      // RSC has no datapath support: no register write, no flag update.
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond.sv
// cond_check: maps a 4-bit condition field and the stored NZCV to a pass bit.
module cond_check
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1; // AL and the reserved 1111 both execute
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for a small ARM-like datapath. Define
// MULTICYCLE_WAIT_EN to compile in the memory handshake, wait timeout and HALT.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg_src,
  output logic        shift,
  output logic        carry,
  output logic        swap,
  output logic        inv,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_ctl,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_write,
  output logic        mem_req,
  output logic        adr_src,
  output logic        fault,
  output logic [3:0]  state
);

  state_t     state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic       cond_pass;
  logic       mem_done;
  logic       unused_ok;
  cmd_dec_t   dec;

  assign dec = decode_cmd(instr[24:21]);

`ifdef MULTICYCLE_WAIT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 2);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  assign mem_done  = mem_ready;
  assign fault     = fault_q;
  assign unused_ok = ^instr[19:0];
`else
  // Zero-wait memory: every access completes in its first cycle.
  assign mem_done  = 1'b1;
  assign fault     = 1'b0;
  assign unused_ok = ^{instr[19:0], mem_ready} ^ (MAX_WAIT < 0);
`endif

  cond_check u_cond (
    .cond (instr[31:28]),
    .nzcv (nzcv_q),
    .pass (cond_pass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      nzcv_q     <= '0;
`ifdef MULTICYCLE_WAIT_EN
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      nzcv_q     <= nzcv_d;
`ifdef MULTICYCLE_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    nzcv_d     = nzcv_q;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_src    = 1'b0;
    shift      = 1'b0;
    carry      = 1'b0;
    swap       = 1'b0;
    inv        = 1'b0;
    imm_src    = 2'b00;
    alu_ctl    = ALU_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    adr_src    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (!cond_pass) begin
          state_d = FETCH;
        end else begin
          case (instr[27:26])
            2'b00:   state_d = instr[25] ? EXECI : EXECR;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        alu_src = 1'b1;
        imm_src = 2'b01;
        alu_ctl = ALU_ADD;
        state_d = instr[20] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_done) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_done) state_d = FETCH;
      end
      EXECR, EXECI: begin
        alu_ctl = dec.alu_ctl;
        swap    = dec.swap;
        inv     = dec.inv;
        shift   = dec.shift;
        carry   = dec.use_carry & nzcv_q[1];
        if (state_q == EXECI) alu_src = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = dec.writes_rd;
        if (instr[20] && dec.supported) nzcv_d = alu_flags;
        state_d = FETCH;
      end
      BRANCH: begin
        reg_src  = 1'b1;
        alu_src  = 1'b1;
        imm_src  = 2'b10;
        alu_ctl  = ALU_ADD;
        pc_src   = 1'b1;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

`ifdef MULTICYCLE_WAIT_EN
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;
    if (mem_req) begin
      if (mem_ready) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q >= WAIT_W'(MAX_WAIT)) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
`endif

    // FETCH is the reset state; keep its handshake strobes quiet while held.
    if (!reset) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, corner
// sequences and random instructions against a transaction-level model.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

`ifdef MULTICYCLE_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_src, reg_write, mem_to_reg, alu_src, reg_src, shift, carry, swap, inv;
  logic [1:0]  imm_src;
  logic [2:0]  alu_ctl;
  logic        pc_write, ir_write, mem_write, mem_req, adr_src, fault;
  logic [3:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_flags  (alu_flags),
    .mem_ready  (mem_ready),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .reg_src    (reg_src),
    .shift      (shift),
    .carry      (carry),
    .swap       (swap),
    .inv        (inv),
    .imm_src    (imm_src),
    .alu_ctl    (alu_ctl),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .mem_req    (mem_req),
    .adr_src    (adr_src),
    .fault      (fault),
    .state      (state)
  );

  // Per-instruction summary: cycle count and how many cycles each strobe was high.
  typedef struct packed {
    logic [3:0] cycles;
    logic [3:0] ir;
    logic [3:0] pcw;
    logic [3:0] pcs;
    logic [3:0] rw;
    logic [3:0] m2r;
    logic [3:0] mw;
    logic [3:0] asrc;
    logic [3:0] cy;
    logic [3:0] mreq;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  fl;
    obs_t        exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic obs_t mk(input int cyc, input int pcw, input int pcs, input int rw,
                              input int m2r, input int mw, input int asrc, input int cy,
                              input int mreq);
    obs_t o;
    o.cycles = 4'(cyc);
    o.ir     = 4'd1;
    o.pcw    = 4'(pcw);
    o.pcs    = 4'(pcs);
    o.rw     = 4'(rw);
    o.m2r    = 4'(m2r);
    o.mw     = 4'(mw);
    o.asrc   = 4'(asrc);
    o.cy     = 4'(cy);
    o.mreq   = 4'(mreq);
    return o;
  endfunction

  // ARM conditions come in pairs: even code tests a predicate, odd code its negation.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b0;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return r ^ c[0];
  endfunction

  // Transaction-level reference: latency and strobe counts of one instruction
  // with zero-wait memory; updates the model flag register.
  function automatic obs_t model_txn(input logic [31:0] ins, input logic [3:0] fl,
                                     inout logic [3:0] nzcv);
    obs_t       e;
    logic [3:0] cmd;
    bit         ok;
    e = mk(2, 1, 0, 0, 0, 0, 0, 0, 1);
    if (!cond_ok(ins[31:28], nzcv)) return e;
    cmd = ins[24:21];
    case (ins[27:26])
      2'b00: begin
        ok       = (cmd != 4'd7);
        e.cycles = 4'd4;
        e.asrc   = 4'(ins[25]);
        e.rw     = 4'(ok && !(cmd >= 4'd8 && cmd <= 4'd11));
        e.cy     = 4'((cmd == 4'd5 || cmd == 4'd6) && nzcv[1]);
        if (ok && ins[20]) nzcv = fl;
      end
      2'b01: begin
        if (ins[20]) e = mk(5, 1, 0, 1, 1, 0, 1, 0, 2);
        else         e = mk(4, 1, 0, 0, 0, 1, 1, 0, 2);
      end
      2'b10:   e = mk(3, 2, 1, 0, 0, 0, 1, 0, 1);
      default: e = mk(2, 1, 0, 0, 0, 0, 0, 0, 1);
    endcase
    return e;
  endfunction

  // Starts in the first half of a FETCH cycle; returns just after the edge
  // that brings the FSM back to FETCH (bounded to 16 cycles).
  task automatic run_txn(input logic [31:0] ins, input logic [3:0] fl,
                         input logic [15:0] ready_mask, output obs_t o);
    int n;
    o = '0;
    n = 0;
    instr = ins;
    alu_flags = fl;
    do begin
      @(negedge clk);
      mem_ready = ready_mask[n[3:0]];
      #1;
      o.ir   = o.ir   + 4'(ir_write);
      o.pcw  = o.pcw  + 4'(pc_write);
      o.pcs  = o.pcs  + 4'(pc_src);
      o.rw   = o.rw   + 4'(reg_write);
      o.m2r  = o.m2r  + 4'(mem_to_reg);
      o.mw   = o.mw   + 4'(mem_write);
      o.asrc = o.asrc + 4'(alu_src);
      o.cy   = o.cy   + 4'(carry);
      o.mreq = o.mreq + 4'(mem_req);
      n++;
      @(posedge clk);
      #1;
    end while (state != 4'(FETCH) && n < 16);
    o.cycles  = 4'(n);
    mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  vec_t       tbl[16];
  obs_t       obs, exp_o;
  logic [3:0] nzcv_m;
  logic [15:0] st_seq;
  logic [2:0]  strobes;
  int          irc;
  logic        bad_seen;

  initial begin
    tbl[0]  = '{32'hE2811005, 4'h0, mk(4, 1, 0, 1, 0, 0, 1, 0, 1)}; // ADD r1,r1,#5
    tbl[1]  = '{32'hE1510002, 4'h4, mk(4, 1, 0, 0, 0, 0, 0, 0, 1)}; // CMP -> Z
    tbl[2]  = '{32'h0A000003, 4'h0, mk(3, 2, 1, 0, 0, 0, 1, 0, 1)}; // BEQ taken
    tbl[3]  = '{32'h1A000003, 4'h0, mk(2, 1, 0, 0, 0, 0, 0, 0, 1)}; // BNE fails
    tbl[4]  = '{32'hE5912000, 4'h0, mk(5, 1, 0, 1, 1, 0, 1, 0, 2)}; // LDR
    tbl[5]  = '{32'hE5812000, 4'h0, mk(4, 1, 0, 0, 0, 1, 1, 0, 2)}; // STR
    tbl[6]  = '{32'hE1510002, 4'h2, mk(4, 1, 0, 0, 0, 0, 0, 0, 1)}; // CMP -> C
    tbl[7]  = '{32'hE0A11002, 4'h0, mk(4, 1, 0, 1, 0, 0, 0, 1, 1)}; // ADC, C=1
    tbl[8]  = '{32'hE0F11002, 4'hF, mk(4, 1, 0, 0, 0, 0, 0, 0, 1)}; // RSCS unsupported
    tbl[9]  = '{32'h0A000003, 4'h0, mk(2, 1, 0, 0, 0, 0, 0, 0, 1)}; // BEQ, Z still 0
    tbl[10] = '{32'hEE000000, 4'h0, mk(2, 1, 0, 0, 0, 0, 0, 0, 1)}; // class 11 no-op
    tbl[11] = '{32'hE3B00001, 4'h8, mk(4, 1, 0, 1, 0, 0, 1, 0, 1)}; // MOVS #1 -> N
    tbl[12] = '{32'h4A000000, 4'h0, mk(3, 2, 1, 0, 0, 0, 1, 0, 1)}; // BMI taken
    tbl[13] = '{32'hE0C11002, 4'h0, mk(4, 1, 0, 1, 0, 0, 0, 0, 1)}; // SBC, C=0
    tbl[14] = '{32'hE1110002, 4'h4, mk(4, 1, 0, 0, 0, 0, 0, 0, 1)}; // TST -> Z
    tbl[15] = '{32'h0A000003, 4'h0, mk(3, 2, 1, 0, 0, 0, 1, 0, 1)}; // BEQ taken

    // Reset held with mem_ready high: only mem_req may be active.
    reset = 1'b0;
    mem_ready = 1'b1;
    instr = 32'hE2811005;
    alu_flags = 4'h0;
    @(negedge clk);
    #1;
    check("reset_state_fault", {fault, state}, {1'b0, 4'(FETCH)});
    check("reset_mem_req", mem_req, 1'b1);
    check("reset_outputs_zero",
          {pc_src, reg_write, mem_to_reg, alu_src, reg_src, shift, carry, swap, inv,
           imm_src, alu_ctl, pc_write, ir_write, mem_write, adr_src}, '0);
    @(posedge clk);
    #1 reset = 1'b1;

    // ADD r1,r1,#5 cycle by cycle.
    st_seq = '0;
    strobes = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      st_seq = {st_seq[11:0], state};
      if (k == 0) strobes[2] = mem_req;
      if (k == 2) strobes[1] = alu_src;
      if (k == 3) strobes[0] = reg_write;
      @(posedge clk);
      #1;
    end
    $display("txn add_seq instr=%08h states=%h", instr, st_seq);
    check("add_state_seq", st_seq, {4'(FETCH), 4'(DECODE), 4'(EXECI), 4'(ALUWB)});
    check("add_strobes", strobes, 3'b111);

    foreach (tbl[i]) begin
      run_txn(tbl[i].ins, tbl[i].fl, 16'hFFFF, obs);
      $display("txn table[%0d] instr=%08h cycles=%0d", i, tbl[i].ins, obs.cycles);
      check($sformatf("table[%0d]", i), obs, tbl[i].exp);
    end

    // LDR with mem_ready low for three MEMRD cycles.
    exp_o = WAIT_EN ? mk(8, 1, 0, 1, 1, 0, 1, 0, 5) : mk(5, 1, 0, 1, 1, 0, 1, 0, 2);
    run_txn(32'hE5912000, 4'h0, 16'hFFC7, obs);
    $display("txn ldr_wait instr=e5912000 cycles=%0d", obs.cycles);
    check("ldr_wait", obs, exp_o);

    // Reset during MEMWR, after Z has been set; flags must come back cleared.
    run_txn(32'hE1510002, 4'h4, 16'hFFFF, obs);
    instr = 32'hE5812000;
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("memwr_active", {mem_write, state}, {1'b1, 4'(MEMWR)});
    #1 reset = 1'b0;
    #1;
    check("memwr_reset_async", {mem_write, mem_req, state}, {1'b0, 1'b1, 4'(FETCH)});
    @(posedge clk);
    #1 reset = 1'b1;
    mem_ready = 1'b1;
    run_txn(32'h1A000003, 4'h0, 16'hFFFF, obs);
    $display("txn bne_after_reset cycles=%0d", obs.cycles);
    check("bne_after_reset", obs, mk(3, 2, 1, 0, 0, 0, 1, 0, 1));

`ifdef MULTICYCLE_WAIT_EN
    do_reset();
    mem_ready = 1'b0;
    instr = 32'hE2811005;
    repeat (15) @(posedge clk);
    #1;
    check("timeout_pre", {fault, state}, {1'b0, 4'(FETCH)});
    @(posedge clk);
    #1;
    check("timeout_fault", {fault, state}, {1'b1, 4'(HALT)});
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("halt_sticky", {fault, mem_req, state}, {1'b1, 1'b0, 4'(HALT)});
    reset = 1'b0;
    #1;
    check("halt_reset", {fault, state}, {1'b0, 4'(FETCH)});
    @(posedge clk);
    #1 reset = 1'b1;
    $display("txn timeout done");
`else
    do_reset();
    mem_ready = 1'b0;
    instr = 32'hEE000000;
    irc = 0;
    bad_seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      #1;
      irc += int'(ir_write);
      if (fault || state == 4'(HALT)) bad_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    $display("txn ready_ignored fetches=%0d", irc);
    check("ready_ignored_fetches", irc, 8);
    check("no_fault_without_wait", bad_seen, 1'b0);
`endif

    // Random instructions against the transaction model.
    do_reset();
    nzcv_m = 4'h0;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] ins;
      logic [3:0]  fl;
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      fl = 4'($urandom_range(0, 15));
      exp_o = model_txn(ins, fl, nzcv_m);
      run_txn(ins, fl, 16'hFFFF, obs);
      $display("txn rand[%0d] instr=%08h flags=%h cycles=%0d", t, ins, fl, obs.cycles);
      check($sformatf("rand[%0d]", t), obs, exp_o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
